// File: rtl/airi5c_dmi_port_pkg.sv
// airi5c_dmi_port_pkg: DMI and register-bus widths shared by the DMI port
package airi5c_dmi_port_pkg;
  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_WIDTH      = 32;
  localparam int TO_CNT_W       = 8;
endpackage

// File: rtl/airi5c_dmi_port.sv
// airi5c_dmi_port: bridges one-cycle DMI strobes to a req/gnt/rvalid register bus with timeout and sticky error
module airi5c_dmi_port
  import airi5c_dmi_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [DMI_ADDR_WIDTH-1:0] dmi_addr,
  input  logic [DMI_WIDTH-1:0]      dmi_wdata,
  input  logic                      dmi_en,
  input  logic                      dmi_wen,
  input  logic                      dmi_reset,
  output logic [DMI_WIDTH-1:0]      dmi_rdata,
  output logic                      dmi_error,
  output logic                      dmi_dm_busy,
  output logic                      dm_req,
  output logic                      dm_we,
  output logic [DMI_ADDR_WIDTH-1:0] dm_addr,
  output logic [DMI_WIDTH-1:0]      dm_wdata,
  input  logic                      dm_gnt,
  input  logic                      dm_rvalid,
  input  logic [DMI_WIDTH-1:0]      dm_rdata,
  input  logic                      dm_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  state_t                    r_state, w_next;
  logic [TO_CNT_W-1:0]       r_cnt;
  logic                      r_req, r_we, r_err;
  logic [DMI_ADDR_WIDTH-1:0] r_addr;
  logic [DMI_WIDTH-1:0]      r_wdata, r_rdata;
  logic                      w_done, w_expire, w_set_err;
  assign w_done      = (r_state == RESP) && dm_rvalid;
  assign w_expire    = (r_state != IDLE) && (r_cnt == TO_LAST) && !w_done;
  assign w_set_err   = (dmi_en && r_state != IDLE) || (w_done && dm_err) || w_expire;
  assign dmi_rdata   = r_rdata;
  assign dmi_error   = r_err;
  assign dmi_dm_busy = (r_state != IDLE);
  assign dm_req      = r_req;
  assign dm_we       = r_we;
  assign dm_addr     = r_addr;
  assign dm_wdata    = r_wdata;
  // next state: accept in IDLE, wait for grant, wait for response; timeout aborts either wait
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = dmi_en ? REQ : IDLE;
    else if (w_expire || w_done)
      w_next = IDLE;
    else if (r_state == REQ && dm_gnt)
      w_next = RESP;
  end
  // state, timeout counter, latched request, read data and sticky error
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE) ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE && dmi_en) begin
        r_req   <= 1'b1;
        r_we    <= dmi_wen;
        r_addr  <= dmi_addr;
        r_wdata <= dmi_wdata;
      end else if (r_state == REQ && (dm_gnt || w_expire)) begin
        r_req <= 1'b0;
      end
      if (w_done && !r_we && !dm_err)
        r_rdata <= dm_rdata;
      else if (w_expire && !r_we)
        r_rdata <= '0;
      r_err <= w_set_err || (r_err && !dmi_reset);
    end
  end
endmodule

// File: tb/tb_airi5c_dmi_port.sv
// tb_airi5c_dmi_port: directed checks of the DMI port with an 8-cycle timeout
module tb_airi5c_dmi_port;
  logic        clk = 1'b0;
  logic        nreset;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic        dmi_en, dmi_wen, dmi_reset;
  logic [31:0] dmi_rdata;
  logic        dmi_error, dmi_dm_busy;
  logic        dm_req, dm_we;
  logic [6:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt, dm_rvalid, dm_err;
  logic [31:0] dm_rdata;
  int          errors = 0;
  int          checks = 0;
  int          busy_cnt = 0;

  airi5c_dmi_port #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .nreset(nreset),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_en(dmi_en), .dmi_wen(dmi_wen),
    .dmi_reset(dmi_reset), .dmi_rdata(dmi_rdata), .dmi_error(dmi_error),
    .dmi_dm_busy(dmi_dm_busy), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_err(dm_err)
  );

  always #5 clk = ~clk;

  // counts busy cycles, sampled mid-cycle
  always @(negedge clk) if (dmi_dm_busy) busy_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full access: strobe, grant on first REQ cycle, response on first RESP cycle
  task automatic access(input logic we, input logic [6:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err);
    dmi_en = 1'b1; dmi_wen = we; dmi_addr = a; dmi_wdata = wd;
    tick();
    dmi_en = 1'b0; dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = rd; dm_err = err;
    tick();
    dm_rvalid = 1'b0; dm_err = 1'b0;
  endtask

  initial begin
    nreset = 1'b0; dmi_addr = '0; dmi_wdata = '0; dmi_en = 1'b0; dmi_wen = 1'b0;
    dmi_reset = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0; dm_err = 1'b0;
    tick(); tick();
    nreset = 1'b1;
    chk("rst_busy", 32'(dmi_dm_busy), 32'd0);
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_rdata", dmi_rdata, 32'd0);
    chk("rst_error", 32'(dmi_error), 32'd0);
    chk("rst_addr", 32'(dm_addr), 32'd0);

    // read with grant on 2nd REQ cycle and response two cycles later
    busy_cnt = 0;
    dmi_en = 1'b1; dmi_wen = 1'b0; dmi_addr = 7'h11;
    tick();
    dmi_en = 1'b0;
    chk("rd_req", 32'(dm_req), 32'd1);
    chk("rd_addr", 32'(dm_addr), 32'h11);
    chk("rd_we", 32'(dm_we), 32'd0);
    tick();
    dm_gnt = 1'b1;
    chk("rd_req_hold", 32'(dm_req), 32'd1);
    tick();
    dm_gnt = 1'b0;
    chk("rd_req_drop", 32'(dm_req), 32'd0);
    chk("rd_busy_resp", 32'(dmi_dm_busy), 32'd1);
    tick();
    dm_rvalid = 1'b1; dm_rdata = 32'h0000_0C82;
    tick();
    dm_rvalid = 1'b0;
    chk("rd_rdata", dmi_rdata, 32'h0000_0C82);
    chk("rd_error", 32'(dmi_error), 32'd0);
    chk("rd_idle", 32'(dmi_dm_busy), 32'd0);
    chk("rd_busy_cycles", 32'(busy_cnt), 32'd4);

    // write; rvalid in REQ is ignored, response keeps dmi_rdata
    dmi_en = 1'b1; dmi_wen = 1'b1; dmi_addr = 7'h10; dmi_wdata = 32'h8000_0001;
    tick();
    dmi_en = 1'b0; dmi_wdata = 32'h0; dmi_addr = 7'h0;
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    chk("wr_we", 32'(dm_we), 32'd1);
    chk("wr_addr", 32'(dm_addr), 32'h10);
    tick();
    dm_rvalid = 1'b0;
    chk("wr_req_ignore_rvalid", 32'(dm_req), 32'd1);
    chk("wr_wdata_stable", dm_wdata, 32'h8000_0001);
    chk("wr_addr_stable", 32'(dm_addr), 32'h10);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    dm_rvalid = 1'b1;
    tick();
    dm_rvalid = 1'b0;
    chk("wr_rdata_kept", dmi_rdata, 32'h0000_0C82);
    chk("wr_idle", 32'(dmi_dm_busy), 32'd0);

    // collision during RESP
    dmi_en = 1'b1; dmi_wen = 1'b0; dmi_addr = 7'h05;
    tick();
    dmi_en = 1'b0; dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0; dmi_en = 1'b1; dmi_addr = 7'h22;
    tick();
    dmi_en = 1'b0;
    chk("col_no_req", 32'(dm_req), 32'd0);
    chk("col_error", 32'(dmi_error), 32'd1);
    chk("col_addr", 32'(dm_addr), 32'h05);
    dm_rvalid = 1'b1; dm_rdata = 32'h0000_1234;
    tick();
    dm_rvalid = 1'b0;
    chk("col_rdata", dmi_rdata, 32'h0000_1234);
    chk("col_error_sticky", 32'(dmi_error), 32'd1);
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
    chk("col_error_clr", 32'(dmi_error), 32'd0);

    // timeout with no grant; first REQ cycle also tests set-beats-clear
    dmi_en = 1'b1; dmi_wen = 1'b0; dmi_addr = 7'h03;
    tick();
    dmi_en = 1'b1; dmi_reset = 1'b1;
    tick();
    dmi_en = 1'b0; dmi_reset = 1'b0;
    chk("set_wins", 32'(dmi_error), 32'd1);
    repeat (6) tick();
    chk("to_req_cycle8", 32'(dm_req), 32'd1);
    tick();
    chk("to_req_drop", 32'(dm_req), 32'd0);
    chk("to_idle", 32'(dmi_dm_busy), 32'd0);
    chk("to_error", 32'(dmi_error), 32'd1);
    chk("to_rdata", dmi_rdata, 32'd0);

    // error response keeps rdata; back-to-back good read first
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
    access(1'b0, 7'h04, 32'h0, 32'hAAAA_5555, 1'b0);
    chk("b2b_rdata", dmi_rdata, 32'hAAAA_5555);
    chk("b2b_error", 32'(dmi_error), 32'd0);
    access(1'b0, 7'h04, 32'h0, 32'hFFFF_FFFF, 1'b1);
    chk("err_flag", 32'(dmi_error), 32'd1);
    chk("err_rdata_kept", dmi_rdata, 32'hAAAA_5555);

    // response on the expiry cycle wins over timeout
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
    dmi_en = 1'b1; dmi_wen = 1'b0; dmi_addr = 7'h06;
    tick();
    dmi_en = 1'b0; dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    repeat (6) tick();
    chk("race_busy_cycle8", 32'(dmi_dm_busy), 32'd1);
    dm_rvalid = 1'b1; dm_rdata = 32'h0BAD_F00D;
    tick();
    dm_rvalid = 1'b0;
    chk("race_rdata", dmi_rdata, 32'h0BAD_F00D);
    chk("race_error", 32'(dmi_error), 32'd0);
    chk("race_idle", 32'(dmi_dm_busy), 32'd0);

    // reset in RESP then stray response
    dmi_en = 1'b1; dmi_wen = 1'b1; dmi_addr = 7'h7F; dmi_wdata = 32'h1357_9BDF;
    tick();
    dmi_en = 1'b0; dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0; nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("rr_busy", 32'(dmi_dm_busy), 32'd0);
    chk("rr_we", 32'(dm_we), 32'd0);
    chk("rr_addr", 32'(dm_addr), 32'd0);
    chk("rr_wdata", dm_wdata, 32'd0);
    chk("rr_rdata", dmi_rdata, 32'd0);
    dm_rvalid = 1'b1; dm_rdata = 32'h0000_0077; dm_err = 1'b1;
    tick();
    dm_rvalid = 1'b0; dm_err = 1'b0;
    chk("stray_busy", 32'(dmi_dm_busy), 32'd0);
    chk("stray_rdata", dmi_rdata, 32'd0);
    chk("stray_error", 32'(dmi_error), 32'd0);
    chk("stray_req", 32'(dm_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
